// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch state encoding, fetch geometry and next-line PC helper.
package fetch_pkg;

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam int INST_BYTES  = 4;
    localparam int FETCH_BYTES = 8;

    // Start of the following fetch line; wraps modulo 2^32.
    function automatic logic [31:0] next_line(input logic [31:0] pc);
        return (pc & ~32'(FETCH_BYTES - 1)) + 32'(FETCH_BYTES);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: redirect, icache request/response and fetch-queue signals of the fetch controller.
interface fetch_if #(parameter int QDEPTH = 8);

    logic                     stall;
    logic                     exc_valid;
    logic [31:0]              exc_addr;
    logic                     br_valid;
    logic [31:0]              br_addr;
    logic                     ireq_valid;
    logic [31:0]              ireq_addr;
    logic                     ireq_ready;
    logic                     iresp_valid;
    logic [63:0]              iresp_data;
    logic [$clog2(QDEPTH):0]  fq_free;
    logic                     fq_push;
    logic [31:0]              fq_pc;
    logic [63:0]              fq_inst;
    logic [1:0]               fq_num;
    logic [31:0]              pc;

    modport master (
        input  stall, exc_valid, exc_addr, br_valid, br_addr, ireq_ready,
               iresp_valid, iresp_data, fq_free,
        output ireq_valid, ireq_addr, fq_push, fq_pc, fq_inst, fq_num, pc
    );

    modport slave (
        output stall, exc_valid, exc_addr, br_valid, br_addr, ireq_ready,
               iresp_valid, iresp_data, fq_free,
        input  ireq_valid, ireq_addr, fq_push, fq_pc, fq_inst, fq_num, pc
    );

endinterface

// File: rtl/fetch_tag_fifo.sv
// fetch_tag_fifo: small circular FIFO holding the PC of each in-flight fetch request.
module fetch_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [31:0]   data_i,
    output logic [31:0]   data_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= inc(wr_q);
            if (pop_i) rd_q <= inc(rd_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC, issues aligned 8-byte icache requests and
// forwards in-order responses to the fetch queue, dropping those made stale by a redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          MAX_OUT  = 2,
    parameter int          QDEPTH   = 8
) (
    input logic     clk,
    input logic     reset,
    fetch_if.master bus
);

    localparam int CW = $clog2(MAX_OUT + 1);

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d, tag, target;
    logic [CW-1:0] inflight, inflight_nx, live, drop_q, drop_d;
    logic          redirect, accept, resp, odd, push_d;
    logic          fq_push_q;
    logic [31:0]   fq_pc_q;
    logic [63:0]   fq_inst_q;
    logic [1:0]    fq_num_q;

    fetch_tag_fifo #(.DEPTH(MAX_OUT), .CW(CW)) u_tags (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .pop_i   (resp),
        .data_i  (pc_q),
        .data_o  (tag),
        .count_o (inflight)
    );

    assign redirect    = bus.exc_valid | bus.br_valid;
    assign target      = bus.exc_valid ? bus.exc_addr : bus.br_addr;
    assign resp        = bus.iresp_valid & (inflight != '0);
    assign accept      = bus.ireq_valid & bus.ireq_ready;
    assign inflight_nx = inflight + CW'(accept) - CW'(resp);
    assign live        = inflight - drop_q;
    assign odd         = tag[$clog2(INST_BYTES)];

    // Only live requests reserve queue space; stale ones will never be pushed.
    assign bus.ireq_valid = (state_q != BOOT) & !bus.stall & !redirect
                          & (int'(inflight) < MAX_OUT)
                          & (int'(bus.fq_free) >= 2 * (int'(live) + 1));
    assign bus.ireq_addr  = {pc_q[31:3], 3'b000};
    assign bus.pc         = pc_q;
    assign bus.fq_push    = fq_push_q;
    assign bus.fq_pc      = fq_pc_q;
    assign bus.fq_inst    = fq_inst_q;
    assign bus.fq_num     = fq_num_q;

    always_comb begin
        pc_d    = redirect ? target : accept ? next_line(pc_q) : pc_q;
        drop_d  = redirect ? inflight_nx : (resp && drop_q != '0) ? drop_q - CW'(1) : drop_q;
        push_d  = resp & (drop_q == '0) & !redirect;
        state_d = (state_q == BOOT) ? RUN
                : (redirect && (state_q == FLUSH || inflight_nx != '0)) ? FLUSH
                : (state_q == FLUSH && drop_d == '0) ? RUN
                : state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            drop_q    <= '0;
            fq_push_q <= 1'b0;
            fq_pc_q   <= '0;
            fq_inst_q <= '0;
            fq_num_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            fq_push_q <= push_d;
            if (push_d) begin
                fq_pc_q   <= tag;
                fq_inst_q <= {bus.iresp_data[63:32], odd ? bus.iresp_data[63:32] : bus.iresp_data[31:0]};
                fq_num_q  <= odd ? 2'd1 : 2'd2;
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(bus.iresp_valid && inflight == '0));

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against an epoch-based
// model in which a response is delivered only if no redirect happened since its request.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int          MAX_OUT  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    fetch_if #(.QDEPTH(8)) bus ();

    fetch_ctrl #(.RESET_PC(RESET_PC), .MAX_OUT(MAX_OUT), .QDEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, cyc = 0, lat = 1;
    bit          rnd_resp = 0, booted = 0;
    logic [31:0] m_pc;
    int          m_ep = 0;
    logic [31:0] q_tag[$];
    int          q_ep[$];
    int          c_due[$];
    bit          e_push = 0;
    logic [31:0] e_pc;
    logic [63:0] e_inst, last_data;
    logic [1:0]  e_num;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive the cache response, compare outputs, advance the model.
    task automatic tick();
        bit          redir, e_req, acc;
        int          live, ep;
        logic [31:0] tgt, t;
        bus.iresp_valid = c_due.size() > 0 && c_due[0] <= cyc && (!rnd_resp || $urandom_range(3) != 0);
        bus.iresp_data  = {$urandom, $urandom};
        @(negedge clk);
        redir = bus.exc_valid | bus.br_valid;
        tgt   = bus.exc_valid ? bus.exc_addr : bus.br_addr;
        live  = 0;
        foreach (q_ep[i]) if (q_ep[i] == m_ep) live++;
        e_req = booted && !bus.stall && !redir && q_tag.size() < MAX_OUT && int'(bus.fq_free) >= 2 * (live + 1);
        chk("ireq_valid", 64'(bus.ireq_valid), 64'(e_req));
        if (e_req) chk("ireq_addr", 64'(bus.ireq_addr), 64'(m_pc & 32'hFFFF_FFF8));
        chk("pc", 64'(bus.pc), 64'(m_pc));
        chk("fq_push", 64'(bus.fq_push), 64'(e_push));
        if (e_push) begin
            chk("fq_pc", 64'(bus.fq_pc), 64'(e_pc));
            chk("fq_num", 64'(bus.fq_num), 64'(e_num));
            chk("fq_inst_lo", 64'(bus.fq_inst[31:0]), 64'(e_inst[31:0]));
            if (e_num == 2'd2) chk("fq_inst_hi", 64'(bus.fq_inst[63:32]), 64'(e_inst[63:32]));
        end
        acc    = e_req && bus.ireq_ready;
        e_push = 0;
        if (bus.iresp_valid) begin
            t  = q_tag.pop_front();
            ep = q_ep.pop_front();
            void'(c_due.pop_front());
            last_data = bus.iresp_data;
            if (ep == m_ep && !redir) begin
                e_push = 1;
                e_pc   = t;
                e_num  = t[2] ? 2'd1 : 2'd2;
                e_inst = t[2] ? {32'h0, bus.iresp_data[63:32]} : bus.iresp_data;
            end
        end
        if (acc) begin
            q_tag.push_back(m_pc);
            q_ep.push_back(m_ep);
            c_due.push_back(cyc + lat);
            m_pc = (m_pc & 32'hFFFF_FFF8) + 32'd8;
        end
        if (redir) begin
            m_ep++;
            m_pc = tgt;
        end
        booted = 1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        bus.iresp_valid = 0;
        bus.exc_valid   = 0;
        bus.br_valid    = 0;
        bus.stall       = 0;
        reset = 1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 0;
        q_tag.delete();
        q_ep.delete();
        c_due.delete();
        m_pc   = RESET_PC;
        e_push = 0;
        booted = 0;
        cyc++;
        chk("rst_pc", 64'(bus.pc), 64'(RESET_PC));
        chk("rst_push", 64'(bus.fq_push), 64'(0));
        chk("rst_req", 64'(bus.ireq_valid), 64'(0));
        chk("rst_fq_pc", 64'(bus.fq_pc), 64'(0));
        chk("rst_fq_inst", bus.fq_inst, 64'(0));
        chk("rst_fq_num", 64'(bus.fq_num), 64'(0));
        chk("rst_state", 64'(dut.state_q), 64'(BOOT));
        chk("rst_drop", 64'(dut.drop_q), 64'(0));
    endtask

    task automatic drain();
        bus.ireq_ready = 0;
        for (int i = 0; i < 64 && q_tag.size() > 0; i++) tick();
        chk("drain", 64'(q_tag.size()), 64'(0));
        tick();
    endtask

    initial begin
        bus.stall = 0; bus.exc_valid = 0; bus.br_valid = 0;
        bus.exc_addr = '0; bus.br_addr = '0; bus.ireq_ready = 0;
        bus.iresp_valid = 0; bus.iresp_data = '0; bus.fq_free = 4'd8;
        // 1: sequential fetch with one-cycle response latency
        do_reset();
        lat = 1; bus.ireq_ready = 1;
        tick();
        chk("t1_req0", 64'(bus.ireq_valid), 64'(1));
        chk("t1_addr0", 64'(bus.ireq_addr), 64'(32'hBFC0_0000));
        tick();
        chk("t1_addr1", 64'(bus.ireq_addr), 64'(32'hBFC0_0008));
        tick();
        chk("t1_addr2", 64'(bus.ireq_addr), 64'(32'hBFC0_0010));
        chk("t1_push0", 64'(bus.fq_push), 64'(1));
        chk("t1_pc0", 64'(bus.fq_pc), 64'(32'hBFC0_0000));
        chk("t1_num0", 64'(bus.fq_num), 64'(2));
        tick();
        chk("t1_pc1", 64'(bus.fq_pc), 64'(32'hBFC0_0008));
        // 2: branch to an odd word with nothing in flight
        drain();
        bus.br_valid = 1; bus.br_addr = 32'h8000_0004;
        tick();
        bus.br_valid = 0;
        chk("t2_pc", 64'(bus.pc), 64'(32'h8000_0004));
        chk("t2_addr", 64'(bus.ireq_addr), 64'(32'h8000_0000));
        chk("t2_state", 64'(dut.state_q), 64'(RUN));
        bus.ireq_ready = 1;
        tick();
        chk("t2_next", 64'(bus.ireq_addr), 64'(32'h8000_0008));
        tick();
        chk("t2_push", 64'(bus.fq_push), 64'(1));
        chk("t2_fq_pc", 64'(bus.fq_pc), 64'(32'h8000_0004));
        chk("t2_num", 64'(bus.fq_num), 64'(1));
        chk("t2_inst", 64'(bus.fq_inst[31:0]), 64'(last_data[63:32]));
        // 3: simultaneous exception and branch with two requests outstanding
        drain();
        lat = 5; bus.ireq_ready = 1;
        tick();
        tick();
        bus.ireq_ready = 0;
        bus.exc_valid = 1; bus.exc_addr = 32'hBFC0_0380;
        bus.br_valid = 1; bus.br_addr = 32'h8000_1000;
        tick();
        bus.exc_valid = 0; bus.br_valid = 0;
        chk("t3_pc", 64'(bus.pc), 64'(32'hBFC0_0380));
        chk("t3_state", 64'(dut.state_q), 64'(FLUSH));
        chk("t3_drop", 64'(dut.drop_q), 64'(2));
        bus.ireq_ready = 1;
        for (int i = 0; i < 30 && !bus.fq_push; i++) tick();
        chk("t3_push", 64'(bus.fq_push), 64'(1));
        chk("t3_fq_pc", 64'(bus.fq_pc), 64'(32'hBFC0_0380));
        // 4: redirect in the same cycle as a response
        drain();
        lat = 2; bus.ireq_ready = 1;
        tick();
        tick();
        bus.ireq_ready = 0;
        bus.br_valid = 1; bus.br_addr = 32'h8000_2000;
        tick();
        bus.br_valid = 0;
        chk("t4_nopush", 64'(bus.fq_push), 64'(0));
        chk("t4_drop", 64'(dut.drop_q), 64'(1));
        chk("t4_flush", 64'(dut.state_q), 64'(FLUSH));
        tick();
        chk("t4_nopush2", 64'(bus.fq_push), 64'(0));
        chk("t4_run", 64'(dut.state_q), 64'(RUN));
        // 5: queue-space throttle
        drain();
        lat = 10; bus.ireq_ready = 1;
        tick();
        bus.ireq_ready = 0;
        bus.fq_free = 4'd3;
        #1;
        chk("t5_full", 64'(bus.ireq_valid), 64'(0));
        bus.fq_free = 4'd4;
        #1;
        chk("t5_room", 64'(bus.ireq_valid), 64'(1));
        drain();
        bus.fq_free = 4'd8;
        // 6: PC wrap, then reset with requests in flight
        bus.br_valid = 1; bus.br_addr = 32'hFFFF_FFF8;
        tick();
        bus.br_valid = 0;
        lat = 5; bus.ireq_ready = 1;
        tick();
        chk("t6_wrap", 64'(bus.pc), 64'(32'h0000_0000));
        tick();
        chk("t6_two", 64'(q_tag.size()), 64'(2));
        do_reset();
        // randomized traffic
        rnd_resp = 1;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(15));
            bus.stall      = $urandom_range(7) == 0;
            bus.fq_free    = 4'($urandom_range(8));
            bus.ireq_ready = $urandom_range(3) != 0;
            bus.exc_valid  = r <= 1;
            bus.br_valid   = r == 0 || r == 2;
            bus.exc_addr   = $urandom;
            bus.br_addr    = $urandom;
            lat = int'($urandom_range(1, 4));
            if ($urandom_range(499) == 0) do_reset();
            else tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
